// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory load/store sequencer.
//   - Access size encodings (SZ_BYTE/SZ_HALF/SZ_WORD; 2'b11 is treated as a word).
//   - FSM state enum (IDLE/RD/WB/WR/DONE).
//   - Helpers for decoding word-sized accesses and detecting misalignment.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WB   = 3'd2,
    WR   = 3'd3,
    DONE = 3'd4
  } state_e;

  // Bit 1 set covers both the word encoding and the reserved one,
  // so the reserved encoding behaves exactly like a word.
  function automatic logic is_word(input logic [1:0] size);
    return size[1];
  endfunction

  // Half needs addr[0]=0; word needs addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    if (is_word(size)) begin
      mis = (lane != 2'b00);
    end else if (size == SZ_HALF) begin
      mis = lane[0];
    end
    return mis;
  endfunction

endpackage

// File: rtl/ls_lane_unit.sv
// ls_lane_unit: combinational byte-lane steering for the load/store sequencer.
//   size_i    access size (dm_pkg encodings)
//   lane_i    byte offset inside the addressed word
//   uns_i     1 = zero-extend loads, 0 = sign-extend
//   base_i    word previously read from dm (store merge base)
//   wdata_i   store data; byte in [7:0], half in [15:0]
//   merged_o  base_i with the addressed byte/half replaced (or wdata_i for words)
//   load_i    raw word read from dm
//   load_o    aligned and extended load result
// Half accesses use lane_i[1] only and words ignore lane_i, which gives the
// forced-aligned behaviour when misaligned addresses are not trapped.
module ls_lane_unit
  import dm_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic        uns_i,
  input  logic [31:0] base_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] merged_o,
  input  logic [31:0] load_i,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Store merge
  always_comb begin
    merged_o = base_i;
    if (is_word(size_i)) begin
      merged_o = wdata_i;
    end else if (size_i == SZ_HALF) begin
      if (lane_i[1]) begin
        merged_o[31:16] = wdata_i[15:0];
      end else begin
        merged_o[15:0] = wdata_i[15:0];
      end
    end else begin
      case (lane_i)
        2'd0:    merged_o[7:0]   = wdata_i[7:0];
        2'd1:    merged_o[15:8]  = wdata_i[7:0];
        2'd2:    merged_o[23:16] = wdata_i[7:0];
        default: merged_o[31:24] = wdata_i[7:0];
      endcase
    end
  end

  // Load extraction and extension
  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = load_i[7:0];
      2'd1:    byte_sel = load_i[15:8];
      2'd2:    byte_sel = load_i[23:16];
      default: byte_sel = load_i[31:24];
    endcase
    half_sel = lane_i[1] ? load_i[31:16] : load_i[15:0];

    load_o = load_i;
    if (!is_word(size_i)) begin
      if (size_i == SZ_HALF) begin
        load_o = {{16{half_sel[15] & ~uns_i}}, half_sel};
      end else begin
        load_o = {{24{byte_sel[7] & ~uns_i}}, byte_sel};
      end
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// dm_access_ctrl: load/store sequencer between the CPU memory stage and a
// word-wide data memory with combinational read and synchronous write.
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   req/wr/size/uns/addr/wdata   request, accepted only while ready=1
//   ready           high in IDLE only
//   ack             one-cycle completion pulse (DONE state)
//   rdata           extended load result, valid from ack until the next accept
//   misalign        pulse with ack for a trapped misaligned access
//   dm_addr/dm_din/dm_we/dm_dout  data-memory interface
// Sub-word stores are read-modify-write (IDLE->RD->WB->DONE); word stores go
// straight to WR; loads read in RD and register the extended result.
// Build option: define ALIGN_CHECK_EN to trap misaligned half/word accesses
// (IDLE->DONE, no dm traffic, rdata=0, misalign=1). Without it misalign is 0
// and the low address bits are ignored for halves/words.
module dm_access_ctrl
  import dm_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              wr,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              ack,
  output logic [DATA_W-1:0] rdata,
  output logic              misalign,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_dout
);

  state_e             state_q, state_d;
  logic               wr_q, wr_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  buf_q, buf_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               mis_q, mis_d;

  logic [ADDR_W-1:0]  waddr;
  logic [DATA_W-1:0]  merged;
  logic [DATA_W-1:0]  load_ext;
  logic               req_mis;

  assign waddr = {addr_q[ADDR_W-1:2], 2'b00};
  assign rdata = rdata_q;

`ifdef ALIGN_CHECK_EN
  assign req_mis = is_misaligned(size, addr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  ls_lane_unit u_lane (
    .size_i   (size_q),
    .lane_i   (addr_q[1:0]),
    .uns_i    (uns_q),
    .base_i   (buf_q),
    .wdata_i  (wdata_q),
    .merged_o (merged),
    .load_i   (dm_dout),
    .load_o   (load_ext)
  );

  // Next-state and outputs; every output depends on state_q only, so an
  // asynchronous reset drops dm_we in the same instant.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    uns_d    = uns_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    buf_d    = buf_q;
    rdata_d  = rdata_q;
    mis_d    = mis_q;
    ready    = 1'b0;
    ack      = 1'b0;
    misalign = 1'b0;
    dm_addr  = '0;
    dm_din   = '0;
    dm_we    = 1'b0;

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (req) begin
          wr_d    = wr;
          size_d  = size;
          uns_d   = uns;
          addr_d  = addr;
          wdata_d = wdata;
          mis_d   = req_mis;
          if (req_mis) begin
            rdata_d = '0;
            state_d = DONE;
          end else if (wr && is_word(size)) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: begin
        dm_addr = waddr;
        buf_d   = dm_dout;
        if (wr_q) begin
          state_d = WB;
        end else begin
          // Extract from dm_dout directly: buf_q only updates on this same edge.
          rdata_d = load_ext;
          state_d = DONE;
        end
      end
      WB: begin
        dm_addr = waddr;
        dm_we   = 1'b1;
        dm_din  = merged;
        state_d = DONE;
      end
      WR: begin
        dm_addr = waddr;
        dm_we   = 1'b1;
        dm_din  = wdata_q;
        state_d = DONE;
      end
      DONE: begin
        ack      = 1'b1;
        misalign = mis_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      buf_q   <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// tb_dm_access_ctrl: scoreboard bench for dm_access_ctrl with a word-wide
// data memory model attached. Expectations come from a byte-addressed
// reference memory; a monitor pops and checks them on every ack.
module tb_dm_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        uns = 1'b0;
  logic [13:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        ready, ack, misalign, dm_we;
  logic [31:0] rdata, dm_din, dm_dout;
  logic [13:0] dm_addr;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int init_idx = 0;
  int txn_no = 0;
  logic [31:0] last_rdata = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_access_ctrl #(.ADDR_W(14), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .ack(ack), .rdata(rdata),
    .misalign(misalign), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
    .dm_dout(dm_dout)
  );

  // Data memory: combinational read, synchronous write, filled with a
  // pattern while reset is held.
  logic [31:0] dm_mem [0:4095];

  function automatic logic [31:0] pat(input int i);
    return (i * 32'h9E3779B9) ^ 32'h5A5A00FF;
  endfunction

  assign dm_dout = dm_mem[dm_addr[13:2]];

  always @(posedge clk) begin
    if (init_idx < 4096) begin
      dm_mem[init_idx[11:0]] <= pat(init_idx);
      init_idx <= init_idx + 1;
    end else if (dm_we) begin
      dm_mem[dm_addr[13:2]] <= dm_din;
    end
  end

  // Reference model: byte-addressed memory
  logic [7:0] ref_b [0:16383];

  typedef struct {
    logic        chk_rdata;
    logic        chk_word;
    logic        mis;
    logic [31:0] rdata;
    logic [31:0] word;
    int          widx;
    int          acc;
    int          lat;
  } exp_t;

  exp_t sb[$];

  function automatic logic [31:0] ref_word(input int ea);
    longint val = 0;
    for (int k = 0; k < 4; k++) val += longint'(ref_b[ea + k]) << (8 * k);
    return val[31:0];
  endfunction

  // Builds the expectation for one accepted access and updates the model.
  function automatic exp_t model(input logic w, input logic [1:0] s, input logic u,
                                 input int a, input logic [31:0] d, input int acc);
    exp_t   e;
    int     nb;
    int     ea;
    longint val;
    nb = (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
    e.acc = acc;
    e.widx = a / 4;
    e.chk_rdata = 1'b0;
    e.chk_word = 1'b0;
    e.rdata = '0;
    e.word = '0;
    e.mis = 1'b0;
`ifdef ALIGN_CHECK_EN
    e.mis = (a % nb) != 0;
`endif
    if (e.mis) begin
      e.lat = 1;
      e.chk_rdata = 1'b1;
      e.rdata = '0;
      return e;
    end
    ea = a - (a % nb);
    if (w) begin
      for (int k = 0; k < nb; k++) ref_b[ea + k] = d[8*k +: 8];
      e.lat = (nb == 4) ? 2 : 3;
      e.chk_word = 1'b1;
      e.word = ref_word(e.widx * 4);
    end else begin
      val = 0;
      for (int k = 0; k < nb; k++) val += longint'(ref_b[ea + k]) << (8 * k);
      if (!u && nb < 4 && val >= (longint'(1) << (8 * nb - 1))) val -= longint'(1) << (8 * nb);
      e.lat = 2;
      e.chk_rdata = 1'b1;
      e.rdata = val[31:0];
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    vectors++;
    if (act !== req_v) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req_v);
    end
  endtask

  // Monitor: pop one expectation per ack
  exp_t mon_e;
  int   mon_lat;
  always @(negedge clk) begin
    if (rst_n && ack) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_ack: got ack=1 with empty scoreboard, required none");
      end else begin
        mon_e = sb.pop_front();
        mon_lat = cyc - mon_e.acc;
        txn_no++;
        $display("txn %0d: lat=%0d misalign=%0b rdata=0x%08h", txn_no, mon_lat, misalign, rdata);
        check("latency", mon_lat, mon_e.lat);
        check("misalign", {31'b0, misalign}, {31'b0, mon_e.mis});
        if (mon_e.chk_rdata) check("rdata", rdata, mon_e.rdata);
        if (mon_e.chk_word) check("dm_word", dm_mem[mon_e.widx], mon_e.word);
        last_rdata = rdata;
      end
    end
  end

  task automatic drive(input logic w, input logic [1:0] s, input logic u,
                       input logic [13:0] a, input logic [31:0] d);
    int t = 0;
    @(negedge clk);
    req = 1'b1; wr = w; size = s; uns = u; addr = a; wdata = d;
    while (!ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: got ready=0 for 50 cycles, required 1");
      req = 1'b0;
      return;
    end
    sb.push_back(model(w, s, u, int'(a), d, cyc));
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((sb.size() != 0 || !ready) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || !ready) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got %0d pending, required 0", sb.size());
    end
    @(negedge clk);
  endtask

  initial begin
    int accepts;
    logic [31:0] p;
    for (int w = 0; w < 4096; w++) begin
      p = pat(w);
      for (int k = 0; k < 4; k++) ref_b[4 * w + k] = p[8*k +: 8];
    end
    repeat (4100) @(posedge clk);
    #1;
    // Reset state
    check("rst_ready", {31'b0, ready}, 32'd1);
    check("rst_ack", {31'b0, ack}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_dm_we", {31'b0, dm_we}, 32'd0);
    check("rst_dm_addr", {18'b0, dm_addr}, 32'd0);
    check("rst_dm_din", dm_din, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset during WB leaves the word untouched
    drive(1'b1, 2'b10, 1'b0, 14'h10, 32'hCAFEF00D);
    wait_idle();
    req = 1'b1; wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 14'h11; wdata = 32'h55;
    @(posedge clk);
    #1 req = 1'b0;
    @(posedge clk);
    #2;
    check("wb_dm_we", {31'b0, dm_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_dm_we", {31'b0, dm_we}, 32'd0);
    check("reset_ready", {31'b0, ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    check("reset_mem", dm_mem[14'h10 >> 2], 32'hCAFEF00D);

    // Word store/load
    drive(1'b1, 2'b10, 1'b0, 14'h20, 32'hDEADBEEF);
    drive(1'b0, 2'b10, 1'b0, 14'h20, 32'h0);
    wait_idle();
    check("lw_20", last_rdata, 32'hDEADBEEF);

    // Byte read-modify-write
    drive(1'b1, 2'b10, 1'b0, 14'h40, 32'h11223344);
    drive(1'b1, 2'b00, 1'b0, 14'h42, 32'h123456AA);
    wait_idle();
    check("sb_word", dm_mem[14'h40 >> 2], 32'h11AA3344);
    drive(1'b0, 2'b00, 1'b0, 14'h42, 32'h0);
    wait_idle();
    check("lb_42", last_rdata, 32'hFFFFFFAA);
    drive(1'b0, 2'b00, 1'b1, 14'h42, 32'h0);
    wait_idle();
    check("lbu_42", last_rdata, 32'h000000AA);

    // Halfword
    drive(1'b1, 2'b10, 1'b0, 14'h50, 32'h0);
    drive(1'b1, 2'b01, 1'b0, 14'h52, 32'hFFFF8001);
    wait_idle();
    check("sh_word", dm_mem[14'h50 >> 2], 32'h80010000);
    drive(1'b0, 2'b01, 1'b0, 14'h52, 32'h0);
    wait_idle();
    check("lh_52", last_rdata, 32'hFFFF8001);
    drive(1'b0, 2'b01, 1'b1, 14'h52, 32'h0);
    wait_idle();
    check("lhu_52", last_rdata, 32'h00008001);

    // Reserved size acts as word
    drive(1'b1, 2'b11, 1'b0, 14'h60, 32'h0BADCAFE);
    drive(1'b0, 2'b11, 1'b1, 14'h60, 32'h0);
    wait_idle();

    // Held req: a load completes every three cycles
    accepts = 0;
    @(negedge clk);
    req = 1'b1; wr = 1'b0; size = 2'b10; uns = 1'b0; addr = 14'h20;
    for (int k = 0; k < 6; k++) begin
      if (ready) begin
        sb.push_back(model(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, cyc));
        accepts++;
      end
      @(posedge clk);
      @(negedge clk);
    end
    req = 1'b0;
    wait_idle();
    check("held_req_accepts", accepts, 32'd2);

    // Misaligned accesses (trapped or forced-aligned depending on build)
    drive(1'b0, 2'b10, 1'b0, 14'h21, 32'h0);
    drive(1'b1, 2'b01, 1'b0, 14'h23, 32'h0000BEEF);
    drive(1'b0, 2'b01, 1'b0, 14'h23, 32'h0);
    drive(1'b0, 2'b10, 1'b0, 14'h20, 32'h0);
    wait_idle();

    // Randomized mix over a small region so loads hit earlier stores
    for (int n = 0; n < 150; n++) begin
      drive($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
            14'(14'h100 + $urandom_range(0, 63)), $urandom);
    end
    wait_idle();
    for (int w = 14'h100 / 4; w < 14'h140 / 4; w++) check("final_mem", dm_mem[w], ref_word(4 * w));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
